// File: rtl/latch_strobe_tx_pkg.sv
// latch_strobe_tx_pkg: shared state encoding and phase-counter sizing for latch_strobe_tx.
`default_nettype none

package latch_strobe_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter holds (phase length - 1), so max phase itself always fits.
  function automatic int phase_cnt_w(input int max_phase);
    return (max_phase < 2) ? 1 : $clog2(max_phase + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/latch_strobe_phase_timer.sv
// latch_strobe_phase_timer: loadable down-counter; tc is high while the count is zero.
`default_nettype none

module latch_strobe_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/latch_strobe_tx.sv
// latch_strobe_tx: serialises a word MSB-first onto lat_d with a lat_e strobe per bit.
// Optional LATCH_STROBE_TX_PARITY_EN appends an even-parity bit as the final bit.
`default_nettype none

module latch_strobe_tx
  import latch_strobe_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              lat_d,
  output logic              lat_e,
  output logic              busy,
  output logic              done
);

`ifdef LATCH_STROBE_TX_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif

  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PH_W = phase_cnt_w(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC));

  localparam logic [PH_W-1:0] SETUP_LD = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] PULSE_LD = PH_W'(PULSE_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LD  = PH_W'(HOLD_CYC - 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(NB - 1);

  state_t          state;
  state_t          state_nx;
  logic [NB-1:0]   shift_reg;
  logic [NB-1:0]   shift_nx;
  logic [NB-1:0]   load_word;
  logic [BC_W-1:0] bit_cnt;
  logic            tmr_load;
  logic [PH_W-1:0] tmr_val;
  logic            tmr_tc;
  logic            accept;
  logic            next_bit;
  logic            frame_end;

`ifdef LATCH_STROBE_TX_PARITY_EN
  assign load_word = {tx_data, ^tx_data};
`else
  assign load_word = tx_data;
`endif

  assign shift_nx = shift_reg << 1;

  latch_strobe_phase_timer #(
    .CNT_W (PH_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_val   = SETUP_LD;
    accept    = 1'b0;
    next_bit  = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          accept   = 1'b1;
          state_nx = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_nx = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_tc) begin
          state_nx = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          if (bit_cnt == '0) begin
            state_nx  = ST_IDLE;
            frame_end = 1'b1;
          end else begin
            state_nx = ST_SETUP;
            next_bit = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ready  <= 1'b1;
      lat_d     <= 1'b0;
      lat_e     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      tx_ready <= (state_nx == ST_IDLE);
      busy     <= (state_nx != ST_IDLE);
      lat_e    <= (state_nx == ST_STROBE);
      done     <= frame_end;
      if (accept) begin
        shift_reg <= load_word;
        lat_d     <= load_word[NB-1];
        bit_cnt   <= LAST_IDX;
      end else if (next_bit) begin
        shift_reg <= shift_nx;
        lat_d     <= shift_nx[NB-1];
        bit_cnt   <= bit_cnt - BC_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_latch_strobe_tx.sv
// tb_latch_strobe_tx: directed stimulus with a frame scoreboard checked by a strobe monitor.
`default_nettype none

module tb_latch_strobe_tx;

  localparam int DATA_W    = 8;
  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 1;
  localparam int T         = SETUP_CYC + PULSE_CYC + HOLD_CYC;
`ifdef LATCH_STROBE_TX_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              lat_d;
  logic              lat_e;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb[$];

  latch_strobe_tx #(
    .DATA_W    (DATA_W),
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .lat_d    (lat_d),
    .lat_e    (lat_e),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic [DATA_W-1:0] w);
`ifdef LATCH_STROBE_TX_PARITY_EN
    return 16'({w, ^w});
`else
    return 16'(w);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs in frame cycle c (cycle 1 = first cycle after the acceptance edge).
  task automatic chk_cycle(input logic [15:0] frame, input int c);
    int idx;
    int ph;
    idx = (c - 1) / T;
    ph  = (c - 1) % T;
    chk($sformatf("lat_d c%0d", c), 32'(lat_d), 32'(frame[NB-1-idx]));
    chk($sformatf("lat_e c%0d", c), 32'(lat_e),
        32'((ph >= SETUP_CYC) && (ph < SETUP_CYC + PULSE_CYC)));
    chk($sformatf("busy c%0d", c), 32'(busy), 32'd1);
    chk($sformatf("tx_ready c%0d", c), 32'(tx_ready), 32'd0);
    chk($sformatf("done c%0d", c), 32'(done), 32'd0);
  endtask

  // Called in frame cycle 1; returns in the done cycle unless rst_at aborts the frame.
  task automatic run_frame(input logic [15:0] frame, input int poke_at, input int rst_at);
    for (int c = 1; c <= NB * T; c++) begin
      chk_cycle(frame, c);
      if (c == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        return;
      end
      if (c == poke_at) begin
        tx_valid = 1'b1;
        tx_data  = '0;
      end
      step();
      if (c == poke_at) tx_valid = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_at_done", 32'(tx_ready), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("lat_d_kept", 32'(lat_d), 32'(frame[0]));
  endtask

  task automatic send(input logic [DATA_W-1:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    sb.push_back(mk_frame(w));
    step();
    tx_valid = 1'b0;
  endtask

  // Strobe monitor: collects one bit per lat_e rise and checks framing against the scoreboard.
  initial begin
    logic        prev_e;
    logic        prev_d;
    logic        cur;
    int          hi;
    int          nbits;
    logic [15:0] bits;
    logic [15:0] exp;
    prev_e = 1'b0; prev_d = 1'b0; cur = 1'b0; hi = 0; nbits = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nbits = 0; bits = '0; hi = 0; prev_e = 1'b0; prev_d = lat_d;
      end else begin
        if (lat_e && !prev_e) begin
          chk("setup_stable", 32'(lat_d), 32'(prev_d));
          bits  = {bits[14:0], lat_d};
          nbits++;
          cur   = lat_d;
          hi    = 1;
        end else if (lat_e) begin
          chk("d_stable_in_strobe", 32'(lat_d), 32'(cur));
          hi++;
        end else if (prev_e) begin
          chk("pulse_len", 32'(hi), 32'(PULSE_CYC));
        end
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_frame", 32'(bits), 32'hFFFF_FFFF);
          end else begin
            exp = sb.pop_front();
            chk("frame_data", 32'(bits), 32'(exp));
            chk("frame_bits", 32'(nbits), 32'(NB));
          end
          nbits = 0;
          bits  = '0;
        end
        prev_e = lat_e;
        prev_d = lat_d;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    step();
    step();
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_lat_e", 32'(lat_e), 32'd0);
    chk("rst_lat_d", 32'(lat_d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // Plain frame.
    send(8'hA5);
    run_frame(mk_frame(8'hA5), 0, 0);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    step();

    // Back-to-back: valid held high, second word accepted in the done cycle.
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    sb.push_back(mk_frame(8'hFF));
    step();
    tx_data = 8'h00;
    sb.push_back(mk_frame(8'h00));
    run_frame(mk_frame(8'hFF), 0, 0);
    step();
    tx_valid = 1'b0;
    run_frame(mk_frame(8'h00), 0, 0);
    step();
    step();

    // Reset mid-frame in cycle 10, then a clean frame.
    send(8'h5A);
    run_frame(mk_frame(8'h5A), 0, 10);
    void'(sb.pop_back());
    chk("abort_lat_e", 32'(lat_e), 32'd0);
    chk("abort_tx_ready", 32'(tx_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      step();
    end
    send(8'h3C);
    run_frame(mk_frame(8'h3C), 0, 0);
    step();
    step();

    // Valid pulsed while busy must be ignored.
    send(8'hA5);
    run_frame(mk_frame(8'hA5), 5, 0);
    for (int i = 0; i < 2 * T; i++) begin
      chk("idle_after_ignore", 32'(busy), 32'd0);
      step();
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
